// File: rtl/cache_refill_ctrl_if.sv
// Lookup, replacement-update, refill and statistics signals
// shared by the cache pipeline, LRU block and memory side.
interface cache_refill_ctrl_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16
);
  logic             LOOKUP_VALID;
  logic             LOOKUP_READY;
  logic [N-1:0]     HIT_WAY;
  logic [N-1:0]     WAY_VALID;
  logic [N-1:0]     LRU_IN;
  logic             LRU_ENB;
  logic [N-1:0]     LRU_USE;
  logic             REFILL_REQ;
  logic [N-1:0]     REFILL_WAY;
  logic             REFILL_ACK;
  logic             REFILL_ERR;
  logic             DONE;
  logic [N-1:0]     DONE_WAY;
  logic             DONE_HIT;
  logic             DONE_ERR;
  logic             CNT_CLR;
  logic [CNT_W-1:0] HIT_CNT;
  logic [CNT_W-1:0] MISS_CNT;

  modport master (
    output LOOKUP_VALID, HIT_WAY, WAY_VALID, LRU_IN,
    output REFILL_ACK, REFILL_ERR, CNT_CLR,
    input  LOOKUP_READY, LRU_ENB, LRU_USE,
    input  REFILL_REQ, REFILL_WAY,
    input  DONE, DONE_WAY, DONE_HIT, DONE_ERR,
    input  HIT_CNT, MISS_CNT
  );

  modport slave (
    input  LOOKUP_VALID, HIT_WAY, WAY_VALID, LRU_IN,
    input  REFILL_ACK, REFILL_ERR, CNT_CLR,
    output LOOKUP_READY, LRU_ENB, LRU_USE,
    output REFILL_REQ, REFILL_WAY,
    output DONE, DONE_WAY, DONE_HIT, DONE_ERR,
    output HIT_CNT, MISS_CNT
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss/refill controller: hit completion, victim choice,
// refill handshake, LRU update strobes and hit/miss statistics.
module cache_refill_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input logic               CLK,
  input logic               RSTN,
  cache_refill_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, VICTIM, REFILL, UPDATE
  } state_e;

  state_e state_q, state_d;
  logic [N-1:0] wv_q, wv_d;
  logic [N-1:0] lru_q, lru_d;
  logic [N-1:0] victim_q, victim_d;
  logic [N-1:0] pick;
  logic         refill_req_q, refill_req_d;
  logic [N-1:0] refill_way_q, refill_way_d;
  logic         lru_enb_q, lru_enb_d;
  logic [N-1:0] lru_use_q, lru_use_d;
  logic         done_q, done_d;
  logic [N-1:0] done_way_q, done_way_d;
  logic         done_hit_q, done_hit_d;
  logic         done_err_q, done_err_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic         hit_inc, miss_inc;

  function automatic logic [N-1:0] lowest(
    input logic [N-1:0] v
  );
    logic [N-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Invalid ways win over LRU; an all-zero LRU falls back to way 0.
  always_comb begin
    pick = lowest(~wv_q);
    if (pick == '0) pick = lowest(lru_q);
    if (pick == '0) pick = N'(1);
  end

  always_comb begin
    state_d      = state_q;
    wv_d         = wv_q;
    lru_d        = lru_q;
    victim_d     = victim_q;
    refill_req_d = refill_req_q;
    refill_way_d = refill_way_q;
    lru_enb_d    = 1'b0;
    lru_use_d    = '0;
    done_d       = 1'b0;
    done_way_d   = '0;
    done_hit_d   = 1'b0;
    done_err_d   = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.LOOKUP_VALID) begin
          if (|bus.HIT_WAY) begin
            hit_inc    = 1'b1;
            lru_enb_d  = 1'b1;
            lru_use_d  = lowest(bus.HIT_WAY);
            done_d     = 1'b1;
            done_way_d = lowest(bus.HIT_WAY);
            done_hit_d = 1'b1;
          end else begin
            miss_inc = 1'b1;
            wv_d     = bus.WAY_VALID;
            lru_d    = bus.LRU_IN;
            state_d  = VICTIM;
          end
        end
      end
      VICTIM: begin
        victim_d     = pick;
        refill_way_d = pick;
        refill_req_d = 1'b1;
        state_d      = REFILL;
      end
      REFILL: begin
        if (bus.REFILL_ACK) begin
          refill_req_d = 1'b0;
          refill_way_d = '0;
          done_d       = 1'b1;
          done_way_d   = victim_q;
          done_err_d   = bus.REFILL_ERR;
          lru_enb_d    = ~bus.REFILL_ERR;
          lru_use_d    = bus.REFILL_ERR ? '0 : victim_q;
          state_d      = UPDATE;
        end
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear beats increment; both counters stick at all-ones.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.CNT_CLR) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_inc && hit_cnt_q != '1)
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      if (miss_inc && miss_cnt_q != '1)
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      wv_q         <= '0;
      lru_q        <= '0;
      victim_q     <= '0;
      refill_req_q <= 1'b0;
      refill_way_q <= '0;
      lru_enb_q    <= 1'b0;
      lru_use_q    <= '0;
      done_q       <= 1'b0;
      done_way_q   <= '0;
      done_hit_q   <= 1'b0;
      done_err_q   <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wv_q         <= wv_d;
      lru_q        <= lru_d;
      victim_q     <= victim_d;
      refill_req_q <= refill_req_d;
      refill_way_q <= refill_way_d;
      lru_enb_q    <= lru_enb_d;
      lru_use_q    <= lru_use_d;
      done_q       <= done_d;
      done_way_q   <= done_way_d;
      done_hit_q   <= done_hit_d;
      done_err_q   <= done_err_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.LOOKUP_READY = (state_q == IDLE);
  assign bus.LRU_ENB      = lru_enb_q;
  assign bus.LRU_USE      = lru_use_q;
  assign bus.REFILL_REQ   = refill_req_q;
  assign bus.REFILL_WAY   = refill_way_q;
  assign bus.DONE         = done_q;
  assign bus.DONE_WAY     = done_way_q;
  assign bus.DONE_HIT     = done_hit_q;
  assign bus.DONE_ERR     = done_err_q;
  assign bus.HIT_CNT      = hit_cnt_q;
  assign bus.MISS_CNT     = miss_cnt_q;

endmodule
